// File: rtl/imem_program_loader.sv
// imem_program_loader: encodes streamed LEGv8 instruction fields into instruction memory,
// appends a B #0 halt word, and holds the CPU until the program is resident.
module imem_program_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [1:0] {IDLE, LOAD, HALT, DONE} state_t;

    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'((1 << ADDR_W) - 1);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
    localparam logic [31:0]     HALT_WORD = 32'h1400_0000;

    state_t          state, state_n;
    logic            accept, legal, fits19, fits9;
    logic            we_n, done_n;
    logic [31:0]     word, wdata_n;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W:0] count_n, count_inc;
    logic [1:0]      err_n;

    assign accept    = in_valid & in_ready;
    assign count_inc = count + ONE;
    // Signed range checks: all bits above the field must equal its sign bit
    assign fits19    = (&in_imm[25:18]) | ~(|in_imm[25:18]);
    assign fits9     = (&in_imm[25:8])  | ~(|in_imm[25:8]);

    always_comb begin
        legal = 1'b1;
        word  = 32'd0;
        case (in_op)
            4'd0: begin
                legal = ~(|in_imm[25:12]);
                word  = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
            end
            4'd1: word = {11'b10101011000, in_rm, 6'b000000, in_rn, in_rd};
            4'd2: word = {11'b11101011000, in_rm, 6'b000000, in_rn, in_rd};
            4'd3: word = {6'b000101, in_imm};
            4'd4: word = {6'b100101, in_imm};
            4'd5: begin
                legal = fits19;
                word  = {8'b01010100, in_imm[18:0], 1'b0, 4'b1011};
            end
            4'd6: begin
                legal = fits19;
                word  = {8'b10110100, in_imm[18:0], in_rd};
            end
            4'd7: word = {11'b11010110000, 5'b11111, 6'b000000, in_rn, 5'b00000};
            4'd8: begin
                legal = fits9;
                word  = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
            end
            4'd9: begin
                legal = fits9;
                word  = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        count_n = count;
        err_n   = err_code;
        we_n    = 1'b0;
        addr_n  = imem_addr;
        wdata_n = imem_wdata;
        case (state)
            IDLE, DONE: if (start) begin
                state_n = LOAD;
                count_n = '0;
                err_n   = 2'd0;
                addr_n  = '0;
            end
            LOAD: if (accept) begin
                if (legal) begin
                    we_n    = 1'b1;
                    addr_n  = count[ADDR_W-1:0];
                    wdata_n = word;
                    count_n = count_inc;
                end else begin
                    err_n = 2'd1;
                end
                // One slot is always reserved for the halt word
                if (in_last) begin
                    state_n = HALT;
                end else if (legal && count_inc == LAST_SLOT) begin
                    state_n = HALT;
                    err_n   = 2'd2;
                end
            end
            HALT: begin
                we_n    = 1'b1;
                addr_n  = count[ADDR_W-1:0];
                wdata_n = HALT_WORD;
                count_n = count_inc;
                state_n = DONE;
            end
            default: ;
        endcase
    end

    assign done_n = (state == DONE) && (state_n == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err_code   <= 2'd0;
            count      <= '0;
        end else begin
            state      <= state_n;
            in_ready   <= state_n == LOAD;
            imem_we    <= we_n;
            imem_addr  <= addr_n;
            imem_wdata <= wdata_n;
            cpu_hold   <= ~done_n;
            done       <= done_n;
            err_code   <= err_n;
            count      <= count_n;
        end
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: table vectors, hand-timed sequences and random sessions
// checked against an arithmetic encoding model.
module tb_imem_program_loader;
    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;
    localparam logic [31:0] HALT_W = 32'h1400_0000;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic start2 = 1'b0, valid2 = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rn = '0, in_rm = '0;
    logic [25:0] in_imm = '0;
    logic in_ready, imem_we, cpu_hold, done;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [1:0] err_code;
    logic [AW:0] count;
    logic ready2, we2, hold2, done2;
    logic [1:0] addr2, err2;
    logic [31:0] wdata2;
    logic [2:0] count2;

    typedef struct {int op; int rd; int rn; int rm; int imm; bit last;} instr_t;
    typedef struct {int addr; logic [31:0] data; int cyc;} wr_t;
    typedef struct {instr_t i; bit legal; logic [31:0] word;} vec_t;

    int vectors = 0, miscompares = 0, cyc = 0;
    wr_t got_q[$], got2_q[$], exp_q[$];
    int exp_err;

    imem_program_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err_code(err_code), .count(count)
    );

    imem_program_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(valid2), .in_ready(ready2),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .in_last(in_last), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
        .cpu_hold(hold2), .done(done2), .err_code(err2), .count(count2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (imem_we) got_q.push_back('{int'(imem_addr), imem_wdata, cyc});
        if (we2) got2_q.push_back('{int'(addr2), wdata2, cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input instr_t i);
        in_op   = 4'(i.op);
        in_rd   = 5'(i.rd);
        in_rn   = 5'(i.rn);
        in_rm   = 5'(i.rm);
        in_imm  = 26'(i.imm);
        in_last = i.last;
    endtask

    // Encoding from opcode base values plus shifted fields
    function automatic bit ref_enc(input instr_t i, output logic [31:0] w);
        longint v;
        bit ok;
        ok = 1'b1;
        v = 0;
        case (i.op)
            0: begin ok = i.imm >= 0 && i.imm <= 4095; v = 64'h9100_0000 + (longint'(i.imm & 'hFFF) << 10) + (i.rn << 5) + i.rd; end
            1: v = 64'hAB00_0000 + (i.rm << 16) + (i.rn << 5) + i.rd;
            2: v = 64'hEB00_0000 + (i.rm << 16) + (i.rn << 5) + i.rd;
            3: v = 64'h1400_0000 + (i.imm & 'h3FF_FFFF);
            4: v = 64'h9400_0000 + (i.imm & 'h3FF_FFFF);
            5: begin ok = i.imm >= -262144 && i.imm <= 262143; v = 64'h5400_0000 + ((i.imm & 'h7FFFF) << 5) + 11; end
            6: begin ok = i.imm >= -262144 && i.imm <= 262143; v = 64'hB400_0000 + ((i.imm & 'h7FFFF) << 5) + i.rd; end
            7: v = 64'hD61F_0000 + (i.rn << 5);
            8: begin ok = i.imm >= -256 && i.imm <= 255; v = 64'hF840_0000 + ((i.imm & 'h1FF) << 12) + (i.rn << 5) + i.rd; end
            9: begin ok = i.imm >= -256 && i.imm <= 255; v = 64'hF800_0000 + ((i.imm & 'h1FF) << 12) + (i.rn << 5) + i.rd; end
            default: ok = 1'b0;
        endcase
        w = v[31:0];
        return ok;
    endfunction

    // Session model: expected write list, halt word appended after last or on reaching DEPTH-1 words
    task automatic model(input instr_t p[$]);
        logic [31:0] w;
        exp_q.delete();
        exp_err = 0;
        foreach (p[k]) begin
            if (ref_enc(p[k], w)) begin
                exp_q.push_back('{exp_q.size(), w, 0});
                if (!p[k].last && exp_q.size() == DEPTH - 1) begin
                    exp_err = 2;
                    break;
                end
            end else begin
                exp_err = 1;
            end
            if (p[k].last) break;
        end
        exp_q.push_back('{exp_q.size(), HALT_W, 0});
    endtask

    task automatic run(input instr_t p[$], input bit rnd, input bit do_start);
        int k, t;
        bit acc;
        got_q.delete();
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        k = 0;
        t = 0;
        while (k < p.size()) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                start = in_ready && $urandom_range(0, 1) == 1;
                tick();
                start = 1'b0;
                continue;
            end
            present(p[k]);
            in_valid = 1'b1;
            start = rnd && in_ready && $urandom_range(0, 7) == 0;
            acc = in_ready;
            tick();
            start = 1'b0;
            if (acc) begin
                k++;
                t = 0;
            end else if (++t > 3) begin
                break;
            end
        end
        in_valid = 1'b0;
        t = 0;
        while (!done && t < 10) begin
            tick();
            t++;
        end
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_done"}, done, 1);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_nwr"}, got_q.size(), exp_q.size());
        n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_addr%0d", tag, k), got_q[k].addr, exp_q[k].addr);
            check($sformatf("%s_data%0d", tag, k), got_q[k].data, exp_q[k].data);
        end
        check({tag, "_count"}, count, exp_q.size());
        check({tag, "_err"}, err_code, exp_err);
    endtask

    function automatic instr_t mk(input int op, input int rd, input int rn, input int rm, input int imm, input bit last);
        instr_t i;
        i = '{op, rd, rn, rm, imm, last};
        return i;
    endfunction

    function automatic instr_t rnd_instr(input bit last);
        instr_t i;
        i.op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        i.rd = $urandom_range(0, 31);
        i.rn = $urandom_range(0, 31);
        i.rm = $urandom_range(0, 31);
        case (i.op)
            0: i.imm = int'($urandom_range(0, 5000)) - 300;
            5, 6: i.imm = int'($urandom_range(0, 600000)) - 300000;
            8, 9: i.imm = int'($urandom_range(0, 600)) - 300;
            default: i.imm = int'($urandom_range(0, (1 << 26) - 1)) - (1 << 25);
        endcase
        i.last = last;
        return i;
    endfunction

    initial begin
        vec_t vt[$];
        instr_t p[$];
        logic [31:0] w;
        int acc2, t;
        logic [5:0] rpat;

        vt = '{
            '{mk(0, 1, 31, 0, 5, 1),        1, 32'h910017E1},
            '{mk(0, 2, 3, 0, 4095, 1),      1, 32'h913FFC62},
            '{mk(0, 2, 3, 0, 4096, 1),      0, 32'h0},
            '{mk(0, 2, 3, 0, -1, 1),        0, 32'h0},
            '{mk(1, 3, 1, 2, 0, 1),         1, 32'hAB020023},
            '{mk(2, 3, 1, 2, 0, 1),         1, 32'hEB020023},
            '{mk(3, 0, 0, 0, -1, 1),        1, 32'h17FFFFFF},
            '{mk(4, 0, 0, 0, 4, 1),         1, 32'h94000004},
            '{mk(5, 0, 0, 0, 262143, 1),    1, 32'h547FFFEB},
            '{mk(5, 0, 0, 0, 262144, 1),    0, 32'h0},
            '{mk(5, 0, 0, 0, -262144, 1),   1, 32'h5480000B},
            '{mk(6, 7, 0, 0, -262145, 1),   0, 32'h0},
            '{mk(8, 4, 5, 0, 255, 1),       1, 32'hF84FF0A4},
            '{mk(8, 4, 5, 0, 256, 1),       0, 32'h0},
            '{mk(9, 4, 5, 0, -256, 1),      1, 32'hF81000A4},
            '{mk(9, 4, 5, 0, -257, 1),      0, 32'h0},
            '{mk(10, 0, 0, 0, 0, 1),        0, 32'h0},
            '{mk(15, 0, 0, 0, 0, 1),        0, 32'h0}
        };

        repeat (3) tick();
        rst = 1'b0;
        check("rst_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        check("rst_count", count, 0);

        // Single ADDI with last, cycle by cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_ready", in_ready, 1);
        check("t1_hold_load", cpu_hold, 1);
        present(mk(0, 1, 31, 0, 5, 1));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_we_n1", imem_we, 1);
        check("t1_addr_n1", imem_addr, 0);
        check("t1_data_n1", imem_wdata, 32'h910017E1);
        check("t1_ready_n1", in_ready, 0);
        tick();
        check("t1_we_n2", imem_we, 1);
        check("t1_addr_n2", imem_addr, 1);
        check("t1_data_n2", imem_wdata, HALT_W);
        check("t1_done_n2", done, 0);
        tick();
        check("t1_done_n3", done, 1);
        check("t1_hold_n3", cpu_hold, 0);
        check("t1_count_n3", count, 2);
        check("t1_err_n3", err_code, 0);
        check("t1_we_n3", imem_we, 0);

        // Restart from DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_hold_rise", cpu_hold, 1);
        check("t2_ready_rise", in_ready, 1);
        check("t2_done_fall", done, 0);
        check("t2_count_clr", count, 0);

        p = '{mk(1, 3, 1, 2, 0, 0), mk(2, 3, 1, 2, 0, 0), mk(8, 4, 5, 0, -8, 0), mk(7, 0, 30, 0, 0, 1)};
        run(p, 0, 0);
        exp_q = '{'{0, 32'hAB020023, 0}, '{1, 32'hEB020023, 0}, '{2, 32'hF85F80A4, 0},
                  '{3, 32'hD61F03C0, 0}, '{4, HALT_W, 0}};
        exp_err = 0;
        compare("b2b");
        for (int k = 1; k < got_q.size(); k++)
            check($sformatf("b2b_cycle%0d", k), got_q[k].cyc - got_q[0].cyc, k);

        p = '{mk(6, 7, 0, 0, -2, 0), mk(5, 0, 0, 0, 3, 0), mk(4, 0, 0, 0, 4, 1)};
        run(p, 0, 1);
        exp_q = '{'{0, 32'hB4FFFFC7, 0}, '{1, 32'h5400006B, 0}, '{2, 32'h94000004, 0}, '{3, HALT_W, 0}};
        exp_err = 0;
        compare("branch");

        p = '{mk(12, 0, 0, 0, 0, 0), mk(0, 1, 31, 0, 4096, 0), mk(0, 1, 31, 0, 5, 1)};
        run(p, 0, 1);
        exp_q = '{'{0, 32'h910017E1, 0}, '{1, HALT_W, 0}};
        exp_err = 1;
        compare("illegal");

        foreach (vt[v]) begin
            p = '{vt[v].i};
            run(p, 0, 1);
            if (vt[v].legal) begin
                exp_q = '{'{0, vt[v].word, 0}, '{1, HALT_W, 0}};
                exp_err = 0;
            end else begin
                exp_q = '{'{0, HALT_W, 0}};
                exp_err = 1;
            end
            compare($sformatf("vec%0d", v));
        end

        // Reset in the middle of a load
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        present(mk(0, 1, 0, 0, 1, 0));
        tick();
        present(mk(0, 2, 0, 0, 2, 0));
        tick();
        in_valid = 1'b0;
        tick();
        check("rst_mid_count_before", count, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_hold", cpu_hold, 1);
        check("rst_mid_count", count, 0);
        check("rst_mid_ready", in_ready, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_we", imem_we, 0);
        p = '{mk(0, 2, 0, 0, 7, 1)};
        run(p, 0, 1);
        exp_q = '{'{0, 32'h91001C02, 0}, '{1, HALT_W, 0}};
        exp_err = 0;
        compare("reload");

        // Small memory overflow with in_valid held high
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        valid2 = 1'b1;
        acc2 = 0;
        rpat = '0;
        for (int k = 0; k < 6; k++) begin
            present(mk(0, k, 1, 0, k + 1, 0));
            rpat[k] = ready2;
            if (ready2) acc2++;
            tick();
        end
        valid2 = 1'b0;
        t = 0;
        while (!done2 && t < 10) begin
            tick();
            t++;
        end
        check("ovf_accepts", acc2, 3);
        check("ovf_ready_pattern", rpat, 6'b000111);
        check("ovf_nwr", got2_q.size(), 4);
        for (int k = 0; k < 3 && k < got2_q.size(); k++) begin
            void'(ref_enc(mk(0, k, 1, 0, k + 1, 0), w));
            check($sformatf("ovf_data%0d", k), got2_q[k].data, w);
        end
        if (got2_q.size() == 4) begin
            check("ovf_halt_addr", got2_q[3].addr, 3);
            check("ovf_halt_data", got2_q[3].data, HALT_W);
        end
        check("ovf_err", err2, 2);
        check("ovf_count", count2, 4);
        check("ovf_done", done2, 1);
        check("ovf_hold", hold2, 0);

        for (int s = 0; s < 30; s++) begin
            int len;
            len = $urandom_range(1, 12);
            p.delete();
            for (int k = 0; k < len; k++) p.push_back(rnd_instr(k == len - 1));
            model(p);
            run(p, 1, 1);
            compare($sformatf("rnd%0d", s));
        end

        for (int s = 0; s < 2; s++) begin
            p.delete();
            for (int k = 0; k < 66; k++)
                p.push_back(mk(0, $urandom_range(0, 31), $urandom_range(0, 31), 0, $urandom_range(0, 4095), k == 65));
            model(p);
            run(p, s == 1, 1);
            compare($sformatf("full%0d", s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
